// File: rtl/uart_loader_if.sv
// UART register port and memory write port of the serial boot loader.
// The loader is the master on both; the UART and memory models are slaves.
interface uart_loader_if;
   logic [3:0]  u_adr_o;
   logic [31:0] u_dat_o;
   logic        u_we_o;
   logic        u_stb_o;
   logic [31:0] u_dat_i;
   logic        u_ack_i;
   logic [31:0] mem_adr_o;
   logic [31:0] mem_dat_o;
   logic [3:0]  mem_sel_o;
   logic        mem_we_o;
   logic        mem_stb_o;
   logic        mem_ack_i;

   modport master (
      output u_adr_o, u_dat_o, u_we_o, u_stb_o,
      input  u_dat_i, u_ack_i,
      output mem_adr_o, mem_dat_o, mem_sel_o, mem_we_o, mem_stb_o,
      input  mem_ack_i
   );

   modport slave (
      input  u_adr_o, u_dat_o, u_we_o, u_stb_o,
      output u_dat_i, u_ack_i,
      input  mem_adr_o, mem_dat_o, mem_sel_o, mem_we_o, mem_stb_o,
      output mem_ack_i
   );
endinterface

// File: rtl/uart_loader.sv
// Serial boot loader: polls the UART, hunts for a framed image
// (MAGIC, ADDR, LEN in words, data), writes it word-by-word to memory,
// echoes an 8-bit checksum back through UART TX and latches the entry address.
module uart_loader #(
   parameter logic [7:0]  MAGIC   = 8'hA5,
   parameter logic [31:0] TIMEOUT = 32'd50000000
) (
   input  logic          clk,
   input  logic          rst_ni,
   input  logic          en_i,
   uart_loader_if.master bus,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [31:0]   entry_o
);

   // Bus/handshake sequencer states
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_POLL    = 4'd1;
   localparam logic [3:0] S_POLLW   = 4'd2;
   localparam logic [3:0] S_RD      = 4'd3;
   localparam logic [3:0] S_RDW     = 4'd4;
   localparam logic [3:0] S_GAP1    = 4'd5;
   localparam logic [3:0] S_GAP2    = 4'd6;
   localparam logic [3:0] S_MEMW    = 4'd7;
   localparam logic [3:0] S_TXPOLL  = 4'd8;
   localparam logic [3:0] S_TXPOLLW = 4'd9;
   localparam logic [3:0] S_TXWR    = 4'd10;
   localparam logic [3:0] S_DONE    = 4'd11;

   // Frame parser phases, orthogonal to the sequencer state
   localparam logic [1:0] P_HUNT = 2'd0;
   localparam logic [1:0] P_ADR  = 2'd1;
   localparam logic [1:0] P_LEN  = 2'd2;
   localparam logic [1:0] P_DATA = 2'd3;

   localparam logic [3:0] UA_TX   = 4'h0;
   localparam logic [3:0] UA_RX   = 4'h4;
   localparam logic [3:0] UA_STAT = 4'h8;

   logic [3:0]  state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [1:0]  idx_q, idx_d;       // byte position within the current field/word
   logic [31:0] addr_q, addr_d;     // frame load address (becomes entry)
   logic [31:0] len_q, len_d;
   logic [31:0] word_q, word_d;     // data word being assembled
   logic [31:0] wptr_q, wptr_d;     // next memory write address
   logic [31:0] left_q, left_d;     // words still to write
   logic [7:0]  sum_q, sum_d;
   logic [31:0] tmo_q, tmo_d;
   logic        err_q, err_d;
   logic [31:0] entry_q, entry_d;

   logic [7:0]  rx_byte;
   logic [31:0] len_shift;
   logic        fetching;
   logic        timing;
   logic        unused_bits;

   assign rx_byte   = bus.u_dat_i[7:0];
   assign len_shift = {rx_byte, len_q[31:8]};

   // Only the byte-fetch loop is guarded by the inter-byte timeout;
   // memory writes and the TX echo may stall for as long as they need.
   assign fetching = (state_q == S_POLL) || (state_q == S_POLLW) ||
                     (state_q == S_RD)   || (state_q == S_RDW)   ||
                     (state_q == S_GAP1) || (state_q == S_GAP2);
   assign timing   = fetching && (phase_q != P_HUNT);

   // UART ack is combinational with strobe and never waited on
   assign unused_bits = ^{bus.u_ack_i, bus.u_dat_i[31:8]};

   // Next-state: sequencer, parser and timeout abort
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      len_d   = len_q;
      word_d  = word_q;
      wptr_d  = wptr_q;
      left_d  = left_q;
      sum_d   = sum_q;
      tmo_d   = timing ? tmo_q + 32'd1 : tmo_q;
      err_d   = 1'b0;
      entry_d = entry_q;

      if (timing && (tmo_q == TIMEOUT)) begin
         // Abort: drop the partial word; words already written stay written
         err_d   = 1'b1;
         phase_d = P_HUNT;
         idx_d   = 2'd0;
         tmo_d   = '0;
         state_d = S_POLL;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en_i) begin
                  state_d = S_POLL;
                  phase_d = P_HUNT;
                  idx_d   = 2'd0;
               end
            end
            S_POLL:  state_d = S_POLLW;
            S_POLLW: state_d = bus.u_dat_i[1] ? S_RD : S_POLL;
            S_RD:    state_d = S_RDW;
            S_RDW: begin
               tmo_d   = '0;
               state_d = S_GAP1;
               case (phase_q)
                  P_HUNT: begin
                     if (rx_byte == MAGIC) begin
                        phase_d = P_ADR;
                        idx_d   = 2'd0;
                        sum_d   = 8'd0;
                     end
                  end
                  P_ADR: begin
                     addr_d = {rx_byte, addr_q[31:8]};
                     idx_d  = idx_q + 2'd1;
                     if (idx_q == 2'd3) phase_d = P_LEN;
                  end
                  P_LEN: begin
                     len_d = len_shift;
                     idx_d = idx_q + 2'd1;
                     if (idx_q == 2'd3) begin
                        wptr_d = addr_q;
                        left_d = len_shift;
                        if (len_shift == 32'd0) state_d = S_TXPOLL;
                        else                    phase_d = P_DATA;
                     end
                  end
                  default: begin
                     word_d = {rx_byte, word_q[31:8]};
                     sum_d  = sum_q + rx_byte;
                     idx_d  = idx_q + 2'd1;
                     if (idx_q == 2'd3) state_d = S_MEMW;
                  end
               endcase
            end
            // Status bits need two quiet cycles to settle before the next poll
            S_GAP1: state_d = S_GAP2;
            S_GAP2: state_d = S_POLL;
            S_MEMW: begin
               if (bus.mem_ack_i) begin
                  wptr_d  = wptr_q + 32'd4;
                  left_d  = left_q - 32'd1;
                  state_d = (left_q == 32'd1) ? S_TXPOLL : S_POLL;
               end
            end
            S_TXPOLL:  state_d = S_TXPOLLW;
            S_TXPOLLW: state_d = bus.u_dat_i[0] ? S_TXPOLL : S_TXWR;
            S_TXWR:    state_d = S_DONE;
            S_DONE: begin
               entry_d = addr_q;
               phase_d = P_HUNT;
               idx_d   = 2'd0;
               state_d = S_POLL;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         phase_q <= P_HUNT;
         idx_q   <= 2'd0;
         addr_q  <= '0;
         len_q   <= '0;
         word_q  <= '0;
         wptr_q  <= '0;
         left_q  <= '0;
         sum_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         entry_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         word_q  <= word_d;
         wptr_q  <= wptr_d;
         left_q  <= left_d;
         sum_q   <= sum_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         entry_q <= entry_d;
      end
   end

   // UART port: single-cycle strobes decoded from state
   always_comb begin
      bus.u_stb_o = (state_q == S_POLL) || (state_q == S_RD) ||
                    (state_q == S_TXPOLL) || (state_q == S_TXWR);
      bus.u_we_o  = (state_q == S_TXWR);
      bus.u_dat_o = (state_q == S_TXWR) ? {24'b0, sum_q} : 32'd0;
      case (state_q)
         S_POLL, S_TXPOLL: bus.u_adr_o = UA_STAT;
         S_RD:             bus.u_adr_o = UA_RX;
         default:          bus.u_adr_o = UA_TX;
      endcase
   end

   // Memory port: strobe held through MEMW, so adr/dat are stable until ack.
   // Byte selects follow the strobe so the idle port reads all-zero.
   always_comb begin
      bus.mem_stb_o = (state_q == S_MEMW);
      bus.mem_we_o  = bus.mem_stb_o;
      bus.mem_sel_o = {4{bus.mem_stb_o}};
      bus.mem_adr_o = wptr_q;
      bus.mem_dat_o = word_q;
   end

   assign busy_o  = (state_q != S_IDLE) && (phase_q != P_HUNT);
   assign done_o  = (state_q == S_DONE);
   assign err_o   = err_q;
   assign entry_o = entry_q;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: frames are queued as UART RX bytes,
// expected memory writes / TX echo / entry addresses are pushed by a
// byte-level reference model, and a negedge monitor (which also plays the
// UART and memory slaves) pops and compares.
module tb_uart_loader;
   localparam logic [31:0] TMO = 32'd100;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        en_i = 1'b0;
   logic        busy_o, done_o, err_o;
   logic [31:0] entry_o;

   uart_loader_if bus();

   uart_loader #(.MAGIC(8'hA5), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_ni(rst_ni), .en_i(en_i), .bus(bus),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .entry_o(entry_o)
   );

   always #5 clk = ~clk;
   assign bus.u_ack_i = bus.u_stb_o;

   int checks = 0, failures = 0;
   logic [7:0]  rx_q[$];
   logic [63:0] exp_mem[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] exp_entry[$];
   int done_seen = 0, err_seen = 0, exp_err = 0;
   int cyc = 0, last_rd_cyc = 0, ustb_cnt = 0;
   bit mem_busy = 0, m_bad = 0;
   logic [31:0] m_adr, m_dat;
   int m_wait = 0, m_delay = 0, delay_mode = 0;
   bit last_st_bit0 = 0, tx_arm = 0, tx_armed_active = 0;
   int tx_busy_left = 0, tx_polls = 0;
   bit entry_chk = 0;
   logic [31:0] entry_want;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=none", nm);
   endtask

   // Reference model: bytes of a frame and everything it must produce
   task automatic push_frame(input logic [31:0] adr, input logic [31:0] len,
                             input logic [7:0] d[$]);
      logic [7:0]  sum;
      logic [31:0] word;
      logic [31:0] l;
      sum = 8'd0;
      l = len;
      rx_q.push_back(8'hA5);
      for (int i = 0; i < 4; i++) rx_q.push_back(adr[8*i +: 8]);
      for (int i = 0; i < 4; i++) rx_q.push_back(l[8*i +: 8]);
      for (int i = 0; i < d.size(); i++) begin
         rx_q.push_back(d[i]);
         sum = sum + d[i];
      end
      for (int w = 0; w < int'(len); w++) begin
         word = {d[4*w+3], d[4*w+2], d[4*w+1], d[4*w]};
         exp_mem.push_back({adr + 32'(4*w), word});
      end
      exp_tx.push_back(sum);
      exp_entry.push_back(adr);
   endtask

   task automatic push_noise(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h5A;
         rx_q.push_back(b);
      end
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_seen < target && n < 5000) begin
         @(posedge clk);
         n++;
      end
      check("frame_done_count", done_seen, target);
   endtask

   // Monitor + UART/memory slave models
   always @(negedge clk) begin
      logic [31:0] st;
      logic [63:0] m;
      int d;
      if (!rst_ni) begin
         bus.mem_ack_i = 1'b0;
         bus.u_dat_i = '0;
         mem_busy = 0;
         entry_chk = 0;
         tx_armed_active = 0;
         tx_busy_left = 0;
      end else begin
         cyc++;
         // memory slave
         if (bus.mem_ack_i) begin
            bus.mem_ack_i = 1'b0;
            mem_busy = 0;
            check("mem_stb_drop_after_ack", bus.mem_stb_o, 0);
         end else if (bus.mem_stb_o) begin
            if (!mem_busy) begin
               mem_busy = 1;
               m_adr = bus.mem_adr_o;
               m_dat = bus.mem_dat_o;
               m_wait = 0;
               m_bad = 0;
               m_delay = delay_mode ? 7 : $urandom_range(0, 7);
            end else if (bus.mem_adr_o !== m_adr || bus.mem_dat_o !== m_dat) m_bad = 1;
            if (bus.mem_sel_o !== 4'hF || bus.mem_we_o !== 1'b1) m_bad = 1;
            if (bus.u_stb_o) m_bad = 1;
            if (m_wait == m_delay) begin
               bus.mem_ack_i = 1'b1;
               check("mem_stable_no_uart", 32'(m_bad), 0);
               if (exp_mem.size() == 0) fail("mem_unexpected_write");
               else begin
                  m = exp_mem.pop_front();
                  check("mem_adr", m_adr, m[63:32]);
                  check("mem_dat", m_dat, m[31:0]);
               end
            end else m_wait++;
         end
         // UART slave
         if (bus.u_stb_o) begin
            ustb_cnt++;
            if (bus.u_we_o) begin
               check("tx_adr", 32'(bus.u_adr_o), 0);
               check("tx_ready_before_write", 32'(last_st_bit0), 0);
               if (tx_armed_active) begin
                  check("tx_busy_poll_count", tx_polls, 21);
                  tx_armed_active = 0;
               end
               if (exp_tx.size() == 0) fail("tx_unexpected_write");
               else check("tx_dat", bus.u_dat_o, {24'h0, exp_tx.pop_front()});
            end else if (bus.u_adr_o == 4'h8) begin
               st = '0;
               if (rx_q.size() > 0 && $urandom_range(0, 3) != 0) st[1] = 1'b1;
               if (tx_busy_left > 0) begin
                  st[0] = 1'b1;
                  tx_busy_left--;
               end
               if (tx_armed_active) tx_polls++;
               last_st_bit0 = st[0];
               bus.u_dat_i = st;
            end else if (bus.u_adr_o == 4'h4) begin
               if (rx_q.size() == 0) fail("rx_underflow");
               else begin
                  bus.u_dat_i = {24'h0, rx_q.pop_front()};
                  last_rd_cyc = cyc;
                  if (rx_q.size() == 0 && tx_arm) begin
                     tx_arm = 0;
                     tx_armed_active = 1;
                     tx_busy_left = 20;
                     tx_polls = 0;
                  end
               end
            end else fail("uart_bad_address");
         end
         // completion / abort
         if (entry_chk) begin
            check("entry_o", entry_o, entry_want);
            check("done_single_pulse", 32'(done_o), 0);
            entry_chk = 0;
         end
         if (done_o) begin
            done_seen++;
            check("busy_in_done", 32'(busy_o), 1);
            check("tx_before_done", exp_tx.size(), 0);
            if (exp_entry.size() == 0) fail("done_unexpected");
            else begin
               entry_want = exp_entry.pop_front();
               entry_chk = 1;
            end
         end
         if (err_o) begin
            err_seen++;
            d = cyc - last_rd_cyc;
            checks++;
            if (d < int'(TMO) || d > int'(TMO) + 8) begin
               failures++;
               $display("FAIL err_latency actual=%0d required=%0d..%0d", d, TMO, TMO + 8);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  dq[$];
      logic [63:0] v;
      logic [31:0] a;
      int n, len;
      bus.u_dat_i = '0;
      bus.mem_ack_i = 1'b0;

      // reset state
      #12;
      check("rst_busy", 32'(busy_o), 0);
      check("rst_done_err", {30'd0, done_o, err_o}, 0);
      check("rst_entry", entry_o, 0);
      check("rst_ustb_mstb", {30'd0, bus.u_stb_o, bus.mem_stb_o}, 0);
      @(posedge clk); #3 rst_ni = 1'b1;

      // en_i low keeps it in IDLE
      repeat (10) @(posedge clk);
      #1 check("idle_no_uart_access", ustb_cnt, 0);
      en_i = 1'b1;

      // frame 1: fixed image, slow memory ack
      delay_mode = 1;
      v = 64'h8877665544332211;
      dq.delete();
      for (int i = 0; i < 8; i++) dq.push_back(v[8*i +: 8]);
      push_frame(32'h1000, 32'd2, dq);
      wait_done(1);
      delay_mode = 0;

      // noise then the same frame; en_i dropped mid-frame is ignored
      rx_q.push_back(8'h00); rx_q.push_back(8'hFF); rx_q.push_back(8'h3C);
      push_frame(32'h1000, 32'd2, dq);
      repeat (30) @(posedge clk);
      en_i = 1'b0;
      wait_done(2);

      // LEN = 0
      dq.delete();
      push_frame(32'h2000, 32'd0, dq);
      wait_done(3);

      // partial frame: two data bytes then silence
      rx_q.push_back(8'hA5);
      for (int i = 0; i < 4; i++) rx_q.push_back(8'h30 + 8'(i));
      rx_q.push_back(8'h02); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
      rx_q.push_back(8'hAA); rx_q.push_back(8'hBB);
      exp_err++;
      n = 0;
      while (err_seen < exp_err && n < 1000) begin
         @(posedge clk);
         n++;
      end
      check("err_pulse_seen", err_seen, exp_err);
      @(negedge clk);
      check("busy_after_abort", 32'(busy_o), 0);

      // full frame after the abort: checksum restarts from zero
      dq.delete();
      for (int i = 0; i < 4; i++) dq.push_back(8'hF0 + 8'(i));
      push_frame(32'h3000, 32'd1, dq);
      wait_done(4);

      // random frames, MAGIC allowed inside data, one wrapping the address space
      for (int f = 0; f < 4; f++) begin
         push_noise($urandom_range(0, 3));
         a = (f == 1) ? 32'hFFFF_FFF8 : $urandom;
         len = (f == 1) ? 3 : $urandom_range(1, 5);
         dq.delete();
         for (int i = 0; i < 4 * len; i++)
            dq.push_back(($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom_range(0, 255)));
         if (f == 3) tx_arm = 1;
         push_frame(a, 32'(len), dq);
         wait_done(5 + f);
      end

      // reset in the middle of a memory write
      en_i = 1'b1;
      dq.delete();
      for (int i = 0; i < 16; i++) dq.push_back(8'($urandom_range(0, 255)));
      push_frame(32'h4000, 32'd4, dq);
      n = 0;
      while (!bus.mem_stb_o && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("mem_stb_before_reset", 32'(bus.mem_stb_o), 1);
      #2 rst_ni = 1'b0;
      #1;
      check("async_rst_mem_stb", {31'd0, bus.mem_stb_o}, 0);
      check("async_rst_ustb", {31'd0, bus.u_stb_o}, 0);
      check("async_rst_flags", {29'd0, busy_o, done_o, err_o}, 0);
      check("async_rst_entry", entry_o, 0);
      rx_q.delete(); exp_mem.delete(); exp_tx.delete(); exp_entry.delete();
      repeat (3) @(posedge clk);
      #3 rst_ni = 1'b1;

      // recovery frame
      n = done_seen;
      dq.delete();
      for (int i = 0; i < 8; i++) dq.push_back(8'($urandom_range(0, 255)));
      push_frame(32'h5000, 32'd2, dq);
      wait_done(n + 1);
      repeat (5) @(posedge clk);

      check("mem_queue_drained", exp_mem.size(), 0);
      check("tx_queue_drained", exp_tx.size(), 0);
      check("entry_queue_drained", exp_entry.size(), 0);
      check("err_count", err_seen, exp_err);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
